// File: rtl/hartslag_regelaar.sv
// Heart-rate measurement controller: synchronises the beat pulse, applies a refractory
// filter, counts accepted beats per fixed window and publishes one count per window.
module hartslag_regelaar #(
    parameter int WINDOW_CYCLES   = 50_000_000,
    parameter int MIN_GAP         = 4,
    parameter int TIMEOUT_WINDOWS = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       ingang_i,
    output logic [7:0] uitvoer_o,
    output logic       geldig_o,
    output logic       bezig_o,
    output logic       overloop_o,
    output logic       alarm_o
);
    typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_PUBLISH} state_t;

    localparam int                GAP_W      = $clog2(MIN_GAP + 1);
    localparam int                ZERO_W     = $clog2(TIMEOUT_WINDOWS + 1);
    localparam logic [27:0]       WIN_LAST   = 28'(WINDOW_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_RELOAD = GAP_W'(MIN_GAP - 1);
    localparam logic [ZERO_W-1:0] ZERO_MAX   = ZERO_W'(TIMEOUT_WINDOWS);

    state_t            state_q, state_d;
    logic              sync1_q, sync2_q, hist_q, strobe_q;
    logic [27:0]       win_q, win_d;
    logic [7:0]        count_q, count_d, cnt_inc;
    logic              sat_q, sat_d, sat_inc;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [ZERO_W-1:0] zero_q, zero_d;
    logic [7:0]        uitvoer_q, uitvoer_d;
    logic              overloop_q, overloop_d;
    logic              alarm_q, alarm_d;
    logic              accept;

    // Two-flop synchroniser followed by a registered rising-edge detector.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            hist_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            sync1_q  <= ingang_i;
            sync2_q  <= sync1_q;
            hist_q   <= sync2_q;
            strobe_q <= sync2_q & ~hist_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            win_q      <= '0;
            count_q    <= '0;
            sat_q      <= 1'b0;
            gap_q      <= '0;
            zero_q     <= '0;
            uitvoer_q  <= '0;
            overloop_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            count_q    <= count_d;
            sat_q      <= sat_d;
            gap_q      <= gap_d;
            zero_q     <= zero_d;
            uitvoer_q  <= uitvoer_d;
            overloop_q <= overloop_d;
            alarm_q    <= alarm_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        count_d    = count_q;
        sat_d      = sat_q;
        gap_d      = gap_q;
        zero_d     = zero_q;
        uitvoer_d  = uitvoer_q;
        overloop_d = overloop_q;
        alarm_d    = alarm_q;

        accept  = strobe_q && (gap_q == '0) && (state_q != S_IDLE);
        cnt_inc = count_q;
        sat_inc = sat_q;
        if (accept) begin
            if (count_q == 8'hFF) sat_inc = 1'b1;
            else                  cnt_inc = count_q + 8'd1;
        end

        // The refractory timer keeps running across window boundaries and rests only in IDLE.
        if (state_q == S_IDLE)  gap_d = '0;
        else if (accept)        gap_d = GAP_RELOAD;
        else if (gap_q != '0)   gap_d = gap_q - GAP_W'(1);

        case (state_q)
            S_IDLE: begin
                if (start_i && !stop_i) begin
                    state_d = S_MEASURE;
                    win_d   = '0;
                    count_d = '0;
                    sat_d   = 1'b0;
                    zero_d  = '0;
                    alarm_d = 1'b0;
                end
            end
            S_MEASURE: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                    win_d   = '0;
                    count_d = '0;
                    sat_d   = 1'b0;
                end else if (win_q == WIN_LAST) begin
                    state_d    = S_PUBLISH;
                    win_d      = '0;
                    count_d    = '0;
                    sat_d      = 1'b0;
                    uitvoer_d  = cnt_inc;
                    overloop_d = sat_inc;
                    if (cnt_inc == 8'd0)
                        zero_d = (zero_q == ZERO_MAX) ? zero_q : zero_q + ZERO_W'(1);
                    else
                        zero_d = '0;
                    alarm_d = (zero_d == ZERO_MAX);
                end else begin
                    win_d   = win_q + 28'd1;
                    count_d = cnt_inc;
                    sat_d   = sat_inc;
                end
            end
            S_PUBLISH: begin
                // A beat taken here already belongs to the next window.
                if (stop_i) begin
                    state_d = S_IDLE;
                    count_d = '0;
                    sat_d   = 1'b0;
                end else begin
                    state_d = S_MEASURE;
                    count_d = cnt_inc;
                    sat_d   = sat_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign uitvoer_o  = uitvoer_q;
    assign geldig_o   = (state_q == S_PUBLISH);
    assign bezig_o    = (state_q != S_IDLE);
    assign overloop_o = overloop_q;
    assign alarm_o    = alarm_q;
endmodule

// File: tb/tb_hartslag_regelaar.sv
// Bench for hartslag_regelaar: directed and random Ingang patterns checked against a
// window-level beat-count model derived from the pulse waveform.
module tb_hartslag_regelaar;
    localparam int WA = 100;
    localparam int GA = 4;
    localparam int WB = 1200;
    localparam int GB = 1;
    localparam int TO = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a, stop_a, ing_a, start_b, stop_b, ing_b;
    logic [7:0] uit_a, uit_b;
    logic       g_a, bz_a, ov_a, al_a, g_b, bz_b, ov_b, al_b;

    always #5 clk = ~clk;

    hartslag_regelaar #(.WINDOW_CYCLES(WA), .MIN_GAP(GA), .TIMEOUT_WINDOWS(TO)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .stop_i(stop_a), .ingang_i(ing_a),
        .uitvoer_o(uit_a), .geldig_o(g_a), .bezig_o(bz_a), .overloop_o(ov_a), .alarm_o(al_a)
    );

    hartslag_regelaar #(.WINDOW_CYCLES(WB), .MIN_GAP(GB), .TIMEOUT_WINDOWS(TO)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .stop_i(stop_b), .ingang_i(ing_b),
        .uitvoer_o(uit_b), .geldig_o(g_b), .bezig_o(bz_b), .overloop_o(ov_b), .alarm_o(al_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int pat[$];
    int obs_g[$], obs_u[$], obs_o[$], obs_a[$];
    int obs_bz_low;
    int exp_u[$], exp_o[$], exp_a[$];

    function automatic int pat_at(input int i);
        return (i >= 0 && i < pat.size()) ? pat[i] : 0;
    endfunction

    task automatic clear_pat(input int len);
        pat.delete();
        for (int i = 0; i < len; i++) pat.push_back(0);
    endtask

    task automatic add_pulses(input int first, input int n, input int hi, input int lo);
        for (int k = 0; k < n; k++)
            for (int h = 0; h < hi; h++) begin
                int idx = first + k * (hi + lo) + h;
                if (idx < pat.size()) pat[idx] = 1;
            end
    endtask

    task automatic add_random(input int first, input int last);
        int i = first;
        bit lvl = 1'b0;
        while (i < last) begin
            int len = $urandom_range(2, 6);
            for (int h = 0; h < len; h++)
                if (i + h < pat.size()) pat[i + h] = lvl ? 1 : 0;
            i += len;
            lvl = ~lvl;
        end
    endtask

    // Beats: a strobe appears 3 cycles after each low-to-high step of the driven level.
    // Window j collects beats in offsets [j*(w+1), (j+1)*(w+1)-1], offset 0 being idle.
    function automatic void model(input int w, input int gap, input int nwin);
        int cnt[$];
        int last = 0;
        bit have = 1'b0;
        int streak = 0;
        exp_u.delete(); exp_o.delete(); exp_a.delete();
        for (int j = 0; j < nwin; j++) cnt.push_back(0);
        for (int i = 1; i < nwin * (w + 1); i++)
            if (pat_at(i - 3) == 1 && pat_at(i - 4) == 0 && (!have || i - last >= gap)) begin
                have = 1'b1;
                last = i;
                cnt[i / (w + 1)]++;
            end
        foreach (cnt[j]) begin
            exp_u.push_back(cnt[j] > 255 ? 255 : cnt[j]);
            exp_o.push_back(cnt[j] > 255 ? 1 : 0);
            streak = (cnt[j] == 0) ? ((streak < TO) ? streak + 1 : TO) : 0;
            exp_a.push_back(streak == TO ? 1 : 0);
        end
    endfunction

    // Starts a session at offset 0, plays pat, records every Geldig, then stops and idles.
    task automatic run_windows(input bit sel, input int nwin);
        int w = sel ? WB : WA;
        int total = nwin * (w + 1);
        obs_g.delete(); obs_u.delete(); obs_o.delete(); obs_a.delete();
        obs_bz_low = 0;
        for (int i = 0; i <= total; i++) begin
            if (sel) begin start_b = (i == 0); ing_b = (pat_at(i) != 0); end
            else     begin start_a = (i == 0); ing_a = (pat_at(i) != 0); end
            @(negedge clk);
            if (sel ? g_b : g_a) begin
                obs_g.push_back(i);
                obs_u.push_back(int'(sel ? uit_b : uit_a));
                obs_o.push_back(int'(sel ? ov_b : ov_a));
                obs_a.push_back(int'(sel ? al_b : al_a));
            end
            if (i >= 1 && !(sel ? bz_b : bz_a)) obs_bz_low++;
            @(posedge clk); #1;
        end
        start_a = 1'b0; start_b = 1'b0; ing_a = 1'b0; ing_b = 1'b0;
        if (sel) stop_b = 1'b1; else stop_a = 1'b1;
        @(posedge clk); #1;
        stop_a = 1'b0; stop_b = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_a = 0; stop_a = 0; ing_a = 0; start_b = 0; stop_b = 0; ing_b = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({uit_a, g_a, bz_a, ov_a, al_a} !== 12'h0) begin
            n_fail++; $display("FAIL reset_outputs_a: got %h, want 0", {uit_a, g_a, bz_a, ov_a, al_a});
        end
        n_checks++;
        if ({uit_b, g_b, bz_b, ov_b, al_b} !== 12'h0) begin
            n_fail++; $display("FAIL reset_outputs_b: got %h, want 0", {uit_b, g_b, bz_b, ov_b, al_b});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            ing_a = ((i % 6) < 3);
            @(negedge clk);
            n_checks++;
            if (bz_a !== 1'b0 || g_a !== 1'b0) begin
                n_fail++; $display("FAIL idle_no_start cycle %0d: bezig=%b geldig=%b, want 0 0", i, bz_a, g_a);
            end
            @(posedge clk); #1;
        end
        ing_a = 1'b0;
        n_checks++;
        if (uit_a !== 8'd0) begin
            n_fail++; $display("FAIL idle_uitvoer: got %0d, want 0", uit_a);
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_basic_count();
        clear_pat(WA + 2);
        add_pulses(5, 7, 3, 10);
        run_windows(1'b0, 1);
        n_checks++;
        if (obs_g.size() !== 1) begin
            n_fail++; $display("FAIL basic_geldig_count: got %0d, want 1", obs_g.size());
        end
        if (obs_g.size() >= 1) begin
            n_checks++;
            if (obs_g[0] !== WA + 1) begin
                n_fail++; $display("FAIL basic_geldig_time: got %0d, want %0d", obs_g[0], WA + 1);
            end
            n_checks++;
            if (obs_u[0] !== 7 || obs_o[0] !== 0) begin
                n_fail++; $display("FAIL basic_value: uitvoer=%0d overloop=%0d, want 7 0", obs_u[0], obs_o[0]);
            end
        end
        n_checks++;
        if (obs_bz_low !== 0) begin
            n_fail++; $display("FAIL basic_bezig: low for %0d cycles, want 0", obs_bz_low);
        end
    endtask

    task automatic test_refractory();
        clear_pat(2 * (WA + 1) + 1);
        add_pulses(0, 1000, 2, 2);
        run_windows(1'b0, 2);
        n_checks++;
        if (obs_g.size() !== 2) begin
            n_fail++; $display("FAIL refr_4_count: got %0d windows, want 2", obs_g.size());
        end
        for (int j = 0; j < 2 && j < obs_g.size(); j++) begin
            n_checks++;
            if (obs_u[j] !== 25 || obs_g[j] !== (j + 1) * (WA + 1)) begin
                n_fail++; $display("FAIL refr_4 win %0d: uitvoer=%0d at %0d, want 25 at %0d",
                                   j, obs_u[j], obs_g[j], (j + 1) * (WA + 1));
            end
        end
        clear_pat(2 * (WA + 1) + 1);
        add_pulses(0, 1000, 2, 1);
        model(WA, GA, 2);
        run_windows(1'b0, 2);
        n_checks++;
        if (obs_g.size() !== 2) begin
            n_fail++; $display("FAIL refr_3_count: got %0d windows, want 2", obs_g.size());
        end
        for (int j = 0; j < 2 && j < obs_g.size(); j++) begin
            n_checks++;
            if (obs_u[j] !== exp_u[j]) begin
                n_fail++; $display("FAIL refr_3 win %0d: uitvoer=%0d, want %0d", j, obs_u[j], exp_u[j]);
            end
        end
    endtask

    task automatic test_saturation();
        clear_pat(2 * (WB + 1) + 1);
        add_pulses(0, 300, 2, 2);
        add_pulses(1300, 5, 3, 10);
        run_windows(1'b1, 2);
        n_checks++;
        if (obs_g.size() !== 2) begin
            n_fail++; $display("FAIL sat_count: got %0d windows, want 2", obs_g.size());
        end
        if (obs_g.size() == 2) begin
            n_checks++;
            if (obs_u[0] !== 255 || obs_o[0] !== 1) begin
                n_fail++; $display("FAIL sat_win0: uitvoer=%0d overloop=%0d, want 255 1", obs_u[0], obs_o[0]);
            end
            n_checks++;
            if (obs_u[1] !== 5 || obs_o[1] !== 0) begin
                n_fail++; $display("FAIL sat_win1: uitvoer=%0d overloop=%0d, want 5 0", obs_u[1], obs_o[1]);
            end
            n_checks++;
            if (obs_g[1] !== 2 * (WB + 1)) begin
                n_fail++; $display("FAIL sat_period: got %0d, want %0d", obs_g[1], 2 * (WB + 1));
            end
        end
    endtask

    task automatic test_alarm();
        int eu[4] = '{0, 0, 0, 1};
        int ea[4] = '{0, 0, 1, 0};
        clear_pat(4 * (WA + 1) + 1);
        add_pulses(3 * (WA + 1) + 10, 1, 3, 3);
        run_windows(1'b0, 4);
        n_checks++;
        if (obs_g.size() !== 4) begin
            n_fail++; $display("FAIL alarm_count: got %0d windows, want 4", obs_g.size());
        end
        for (int j = 0; j < 4 && j < obs_g.size(); j++) begin
            n_checks++;
            if (obs_u[j] !== eu[j] || obs_a[j] !== ea[j]) begin
                n_fail++; $display("FAIL alarm win %0d: uitvoer=%0d alarm=%0d, want %0d %0d",
                                   j, obs_u[j], obs_a[j], eu[j], ea[j]);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            clear_pat(3 * (WA + 1) + 1);
            add_random(0, 3 * (WA + 1) + 1);
            model(WA, GA, 3);
            run_windows(1'b0, 3);
            n_checks++;
            if (obs_g.size() !== 3) begin
                n_fail++; $display("FAIL rand%0d_count: got %0d windows, want 3", r, obs_g.size());
            end
            for (int j = 0; j < 3 && j < obs_g.size(); j++) begin
                n_checks++;
                if (obs_g[j] !== (j + 1) * (WA + 1) || obs_u[j] !== exp_u[j] ||
                    obs_o[j] !== exp_o[j] || obs_a[j] !== exp_a[j]) begin
                    n_fail++;
                    $display("FAIL rand%0d win %0d: t=%0d u=%0d o=%0d a=%0d, want t=%0d u=%0d o=%0d a=%0d",
                             r, j, obs_g[j], obs_u[j], obs_o[j], obs_a[j],
                             (j + 1) * (WA + 1), exp_u[j], exp_o[j], exp_a[j]);
                end
            end
        end
    endtask

    task automatic test_abort();
        int seen_g = 0;
        clear_pat(WA + 2);
        add_pulses(10, 3, 3, 10);
        run_windows(1'b0, 1);
        n_checks++;
        if (obs_u.size() !== 1 || obs_u[0] !== 3) begin
            n_fail++; $display("FAIL abort_setup: got %0d windows, want one with uitvoer 3", obs_u.size());
        end
        clear_pat(61);
        add_random(0, 45);
        for (int i = 0; i <= 60; i++) begin
            start_a = (i == 0);
            stop_a  = (i == 50);
            ing_a   = (pat_at(i) != 0);
            @(negedge clk);
            if (g_a) seen_g++;
            if (i == 49) begin
                n_checks++;
                if (bz_a !== 1'b1) begin
                    n_fail++; $display("FAIL abort_busy_before: bezig=%b, want 1", bz_a);
                end
            end
            if (i == 51) begin
                n_checks++;
                if (bz_a !== 1'b0) begin
                    n_fail++; $display("FAIL abort_bezig: bezig=%b, want 0", bz_a);
                end
            end
            @(posedge clk); #1;
        end
        start_a = 1'b0; stop_a = 1'b0; ing_a = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (g_a) seen_g++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen_g !== 0) begin
            n_fail++; $display("FAIL abort_geldig: got %0d strobes, want 0", seen_g);
        end
        n_checks++;
        if (uit_a !== 8'd3 || ov_a !== 1'b0 || al_a !== 1'b0) begin
            n_fail++; $display("FAIL abort_hold: uitvoer=%0d overloop=%b alarm=%b, want 3 0 0", uit_a, ov_a, al_a);
        end
        start_a = 1'b1; stop_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; stop_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (bz_a !== 1'b0) begin
                n_fail++; $display("FAIL start_stop_idle cycle %0d: bezig=%b, want 0", i, bz_a);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        clear_pat(50);
        add_pulses(5, 3, 3, 10);
        for (int i = 0; i <= 40; i++) begin
            start_a = (i == 0);
            ing_a   = (pat_at(i) != 0);
            @(posedge clk); #1;
        end
        start_a = 1'b0;
        n_checks++;
        if (bz_a !== 1'b1 || uit_a !== 8'd3 || uit_b !== 8'd5) begin
            n_fail++; $display("FAIL pre_reset: bezig=%b uit_a=%0d uit_b=%0d, want 1 3 5", bz_a, uit_a, uit_b);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({uit_a, g_a, bz_a, ov_a, al_a} !== 12'h0 || uit_b !== 8'd0) begin
            n_fail++; $display("FAIL reset_mid: a=%h uit_b=%0d, want 0 0", {uit_a, g_a, bz_a, ov_a, al_a}, uit_b);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        ing_a = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bz_a !== 1'b0 || uit_a !== 8'd0) begin
            n_fail++; $display("FAIL post_reset_idle: bezig=%b uitvoer=%0d, want 0 0", bz_a, uit_a);
        end
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_refractory();
        test_saturation();
        test_alarm();
        test_random();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
